axi4lite_mask_responder: RTL and testbench

AXI4-Lite responder that lets the MSS (or any fabric AXI initiator) read and write a register-mapped LSB-masking unit. An initiator writes a 32-bit operand and a 5-bit shift count; the block returns the operand with its n least-significant bits cleared. It sits on the fabric side of the FIC AXI4-Lite interconnect and answers single-beat reads and writes with OKAY/SLVERR responses.

---
 rtl/axi4lite_mask_pkg.sv | 44 ++++
 rtl/axi4lite_mask_responder_lsb_mask32.sv | 12 +
 rtl/axi4lite_mask_responder.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi4lite_mask_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_mask_pkg.sv
// Shared types and constants for the AXI4-Lite LSB-masking responder.
// Optional byte-strobe support is selected with MASK_RESPONDER_WSTRB_EN.
package axi4lite_mask_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned SHIFT_W = 5;

  // Register byte offsets (only address bits [3:2] decode)
  localparam logic [3:0] OFF_VALUE  = 4'h0;
  localparam logic [3:0] OFF_SHIFT  = 4'h4;
  localparam logic [3:0] OFF_RESULT = 4'h8;
  localparam logic [3:0] OFF_ID     = 4'hC;

  localparam logic [DATA_W-1:0] ID_DEFAULT = 32'h4D41_534B;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Byte-lane merge of new write data into an existing word
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_mask_responder_lsb_mask32.sv
// Clears the n least-significant bits of a 32-bit operand.
module lsb_mask32
  import axi4lite_mask_pkg::*;
(
  input  logic [SHIFT_W-1:0] n,
  input  logic [DATA_W-1:0]  operand,
  output logic [DATA_W-1:0]  result_c
);

  assign result_c = operand & (32'hFFFF_FFFF << n);

endmodule

// File: rtl/axi4lite_mask_responder.sv
// AXI4-Lite responder around a register-mapped LSB-masking unit.
// Define MASK_RESPONDER_WSTRB_EN to honour byte strobes on register writes.
module axi4lite_mask_responder
  import axi4lite_mask_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = ID_DEFAULT
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready
);

  // Write-side state
  w_state_t            w_state_q, w_state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;

  // Register file
  logic [DATA_W-1:0]   value_q, value_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]   result_q;
  logic [DATA_W-1:0]   mask_c;

  // Read-side state
  r_state_t            r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  resp_t               rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Write decode helpers
  logic                aw_hs, w_hs;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [3:0]          wr_off;
  logic                wr_err;

  // Read decode helpers
  logic [3:0]          rd_off;
  logic                rd_err;

  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], araddr[1:0]};

  // RESULT is computed from the post-write VALUE/SHIFT so it never lags them
  lsb_mask32 u_mask (
    .n        (shift_d),
    .operand  (value_d),
    .result_c (mask_c)
  );

  // Write state register and register file
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      value_q   <= '0;
      shift_q   <= '0;
      result_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      value_q   <= value_d;
      shift_q   <= shift_d;
      result_q  <= mask_c;
    end
  end

  // Write FSM: collect AW and W in any order, commit, then hold the response
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    value_d   = value_q;
    shift_d   = shift_q;

    aw_hs   = awvalid & awready_q;
    w_hs    = wvalid & wready_q;
    wr_addr = aw_held_q ? awaddr_q : awaddr;
    wr_data = w_held_q ? wdata_q : wdata;
    wr_strb = w_held_q ? wstrb_q : wstrb;
    wr_off  = {wr_addr[3:2], 2'b00};
    wr_err  = (|wr_addr[ADDR_W-1:4]) || (wr_off == OFF_RESULT) ||
              (wr_off == OFF_ID) || (wr_strb == '0);

    unique case (w_state_q)
      W_IDLE: begin
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_err ? SLVERR : OKAY;
          if (!wr_err) begin
            unique case (wr_off)
`ifdef MASK_RESPONDER_WSTRB_EN
              OFF_VALUE: value_d = merge_bytes(value_q, wr_data, wr_strb);
              OFF_SHIFT: if (wr_strb[0]) shift_d = wr_data[SHIFT_W-1:0];
`else
              OFF_VALUE: value_d = wr_data;
              OFF_SHIFT: shift_d = wr_data[SHIFT_W-1:0];
`endif
              default: ;
            endcase
          end
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
          end
          awready_d = !(aw_held_q || aw_hs);
          wready_d  = !(w_held_q || w_hs);
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read FSM: capture data from the current (pre-write) registers on accept
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    rd_off = {araddr[3:2], 2'b00};
    rd_err = |araddr[ADDR_W-1:4];

    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = rd_err ? SLVERR : OKAY;
          rdata_d   = '0;
          if (!rd_err) begin
            unique case (rd_off)
              OFF_VALUE:  rdata_d = value_q;
              OFF_SHIFT:  rdata_d = {{(DATA_W-SHIFT_W){1'b0}}, shift_q};
              OFF_RESULT: rdata_d = result_q;
              OFF_ID:     rdata_d = ID_VALUE;
              default:    rdata_d = '0;
            endcase
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4lite_mask_responder.sv
// Directed bench for axi4lite_mask_responder: vector table plus stall/reset sequence.
module tb_axi4lite_mask_responder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4lite_mask_responder dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [1:0] R_OK  = 2'b00;
  localparam logic [1:0] R_ERR = 2'b10;

`ifdef MASK_RESPONDER_WSTRB_EN
  localparam logic [31:0] EXP_STRB_VALUE = 32'hFF22_FF44;
`else
  localparam logic [31:0] EXP_STRB_VALUE = 32'h1122_3344;
`endif

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly, input logic [1:0] resp);
    vecs.push_back('{1'b1, a, d, s, aw_dly, w_dly, resp, 32'h0});
  endtask

  task automatic add_rd(input logic [7:0] a, input logic [1:0] resp, input logic [31:0] d);
    vecs.push_back('{1'b0, a, 32'h0, 4'h0, 0, 0, resp, d});
  endtask

  // Issue one write; AW and W valids rise after their own delays
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input bit take_b,
                           output logic [1:0] resp);
    int cyc;
    bit aw_done, w_done, hs_aw, hs_w;
    cyc = 0; aw_done = 0; w_done = 0;
    bready = take_b;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(posedge aclk); #1;
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("write handshake", 32'(aw_done && w_done), 32'd1);
    check("bvalid one cycle after last beat", 32'(bvalid), 32'd1);
    resp = bresp;
    if (take_b) begin
      @(posedge aclk); #1;
      check("bvalid drops after bready", 32'(bvalid), 32'd0);
    end
  endtask

  // Issue one read; returns data captured in the first rvalid cycle
  task automatic axi_read(input logic [7:0] a, input bit take_r,
                          output logic [1:0] resp, output logic [31:0] d);
    int cyc;
    bit done, hs;
    cyc = 0; done = 0;
    rready = take_r;
    araddr = a;
    while (!done && cyc < 20) begin
      arvalid = 1'b1;
      hs = arready;
      @(posedge aclk); #1;
      done = hs;
      cyc++;
    end
    arvalid = 1'b0;
    check("read handshake", 32'(done), 32'd1);
    check("rvalid one cycle after AR", 32'(rvalid), 32'd1);
    resp = rresp;
    d = rdata;
    if (take_r) begin
      @(posedge aclk); #1;
      check("rvalid drops after rready", 32'(rvalid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [31:0] held_rdata;

    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    check("rst awready", 32'(awready), 32'd0);
    check("rst wready", 32'(wready), 32'd0);
    check("rst arready", 32'(arready), 32'd0);
    check("rst bvalid", 32'(bvalid), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst rdata", rdata, 32'd0);
    aresetn = 1'b1;
    #1;
    check("readies low before first clock", 32'({awready, wready, arready}), 32'd0);
    @(posedge aclk); #1;
    check("readies high after first clock", 32'({awready, wready, arready}), 32'd7);

    // Vector table
    add_rd(8'h00, R_OK, 32'h0);
    add_rd(8'h04, R_OK, 32'h0);
    add_rd(8'h08, R_OK, 32'h0);
    add_rd(8'h0C, R_OK, 32'h4D41_534B);
    add_wr(8'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, R_OK);
    add_wr(8'h04, 32'd8, 4'hF, 0, 1, R_OK);
    add_rd(8'h08, R_OK, 32'hDEAD_BE00);
    add_rd(8'h00, R_OK, 32'hDEAD_BEEF);
    add_wr(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, R_OK);
    add_wr(8'h04, 32'd31, 4'hF, 0, 0, R_OK);
    add_rd(8'h08, R_OK, 32'h8000_0000);
    add_wr(8'h04, 32'd0, 4'hF, 1, 0, R_OK);
    add_rd(8'h08, R_OK, 32'hFFFF_FFFF);
    add_wr(8'h04, 32'hFFFF_FFE3, 4'hF, 0, 0, R_OK);
    add_rd(8'h04, R_OK, 32'h0000_0003);
    add_rd(8'h08, R_OK, 32'hFFFF_FFF8);
    add_wr(8'h08, 32'h0000_1234, 4'hF, 0, 0, R_ERR);
    add_wr(8'h0C, 32'h0000_1234, 4'hF, 0, 0, R_ERR);
    add_wr(8'h10, 32'h0000_1234, 4'hF, 0, 0, R_ERR);
    add_wr(8'h00, 32'h0000_1234, 4'h0, 0, 0, R_ERR);
    add_rd(8'h00, R_OK, 32'hFFFF_FFFF);
    add_rd(8'h04, R_OK, 32'h0000_0003);
    add_rd(8'h08, R_OK, 32'hFFFF_FFF8);
    add_rd(8'h10, R_ERR, 32'h0);
    add_rd(8'h4C, R_ERR, 32'h0);
    add_wr(8'h00, 32'h1122_3344, 4'b0101, 0, 0, R_OK);
    add_rd(8'h00, R_OK, EXP_STRB_VALUE);
    add_rd(8'h08, R_OK, EXP_STRB_VALUE & 32'hFFFF_FFF8);
    add_wr(8'h04, 32'd12, 4'hF, 2, 0, R_OK);
    add_rd(8'h08, R_OK, EXP_STRB_VALUE & 32'hFFFF_F000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly,
                  1'b1, resp);
        check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, 1'b1, resp, d);
        check($sformatf("vec%0d rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        check($sformatf("vec%0d rdata", i), d, vecs[i].exp_rdata);
      end
    end

    // Back-pressure: hold both responses, verify stability and no new accepts
    axi_write(8'h00, 32'hAAAA_5555, 4'hF, 0, 0, 1'b0, resp);
    check("stall bresp", 32'(resp), 32'(R_OK));
    axi_read(8'h00, 1'b0, resp, held_rdata);
    check("stall rdata new value", held_rdata, 32'hAAAA_5555);
    awaddr = 8'h04; awvalid = 1'b1; wvalid = 1'b1; araddr = 8'h04; arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      check($sformatf("stall%0d bvalid", c), 32'(bvalid), 32'd1);
      check($sformatf("stall%0d rvalid", c), 32'(rvalid), 32'd1);
      check($sformatf("stall%0d rdata", c), rdata, held_rdata);
      check($sformatf("stall%0d awready", c), 32'(awready), 32'd0);
      check($sformatf("stall%0d arready", c), 32'(arready), 32'd0);
    end

    // Reset while both responses are pending
    #2;
    aresetn = 1'b0;
    #1;
    check("reset drops bvalid", 32'(bvalid), 32'd0);
    check("reset drops rvalid", 32'(rvalid), 32'd0);
    check("reset clears rdata", rdata, 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    axi_read(8'h00, 1'b1, resp, d);
    check("post-reset VALUE", d, 32'h0);
    axi_read(8'h04, 1'b1, resp, d);
    check("post-reset SHIFT", d, 32'h0);
    axi_read(8'h08, 1'b1, resp, d);
    check("post-reset RESULT", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
